// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register file with write-back bypass, immediate
// extension and operand-B select, feeding an ID/EX latch with stall and flush.
module operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [15:0]       imm,
    input  logic              signext,
    input  logic              alusrc,
    input  logic [2:0]        alucontrol_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [2:0]        alucontrol,
    output logic [DATA_W-1:0] rt_data,
    output logic              valid_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op_b;

    assign wr_en = we && (wa != '0);

    // NOTE: every entry is cleared on reset so no X can ever reach the ALU operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Same-cycle write-back is forwarded so the instruction in decode sees it.
    always_comb begin
        rs_val = regs[rs];
        if (rs == '0) begin
            rs_val = '0;
        end else if (wr_en && (wa == rs)) begin
            rs_val = wd;
        end
    end

    always_comb begin
        rt_val = regs[rt];
        if (rt == '0) begin
            rt_val = '0;
        end else if (wr_en && (wa == rt)) begin
            rt_val = wd;
        end
    end

    assign imm_ext = signext ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};
    assign op_b    = alusrc ? imm_ext : rt_val;

    // NOTE: flush is tested before stall so a bubble can be inserted into a held slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            rt_data    <= '0;
            alucontrol <= '0;
            valid_out  <= 1'b0;
        end else if (flush) begin
            x          <= '0;
            y          <= '0;
            rt_data    <= '0;
            alucontrol <= '0;
            valid_out  <= 1'b0;
        end else if (!stall) begin
            x          <= rs_val;
            y          <= op_b;
            rt_data    <= rt_val;
            alucontrol <= alucontrol_in;
            valid_out  <= valid_in;
        end
    end

endmodule
